// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module : adder_pkg
// Brief  : State encoding, bsel codes and per-state control words for the
//          A+B+C+D sequencer.
// Rev    : 1.0
// ============================================================================
package adder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ADD_AB = 3'd2,
    ST_ADD_C  = 3'd3,
    ST_ADD_D  = 3'd4,
    ST_OUT    = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  localparam logic [1:0] SEL_AB   = 2'b00;
  localparam logic [1:0] SEL_C    = 2'b01;
  localparam logic [1:0] SEL_D    = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  typedef struct packed {
    logic       aload;
    logic       bload;
    logic       cload;
    logic       dload;
    logic       asel;
    logic [1:0] bsel;
    logic       output_enable;
    logic       done;
  } ctrl_t;

  localparam ctrl_t CW_IDLE   = '{aload: 1'b0, bload: 1'b0, cload: 1'b0, dload: 1'b0,
                                  asel: 1'b0, bsel: SEL_IDLE, output_enable: 1'b0, done: 1'b0};
  localparam ctrl_t CW_LOAD   = '{aload: 1'b1, bload: 1'b1, cload: 1'b1, dload: 1'b1,
                                  asel: 1'b0, bsel: SEL_IDLE, output_enable: 1'b0, done: 1'b0};
  localparam ctrl_t CW_ADD_AB = '{aload: 1'b0, bload: 1'b0, cload: 1'b0, dload: 1'b0,
                                  asel: 1'b1, bsel: SEL_AB, output_enable: 1'b0, done: 1'b0};
  localparam ctrl_t CW_ADD_C  = '{aload: 1'b0, bload: 1'b0, cload: 1'b0, dload: 1'b0,
                                  asel: 1'b0, bsel: SEL_C, output_enable: 1'b0, done: 1'b0};
  localparam ctrl_t CW_ADD_D  = '{aload: 1'b0, bload: 1'b0, cload: 1'b0, dload: 1'b0,
                                  asel: 1'b0, bsel: SEL_D, output_enable: 1'b0, done: 1'b0};
  localparam ctrl_t CW_OUT    = '{aload: 1'b0, bload: 1'b0, cload: 1'b0, dload: 1'b0,
                                  asel: 1'b0, bsel: SEL_IDLE, output_enable: 1'b1, done: 1'b0};
  localparam ctrl_t CW_DONE   = '{aload: 1'b0, bload: 1'b0, cload: 1'b0, dload: 1'b0,
                                  asel: 1'b0, bsel: SEL_IDLE, output_enable: 1'b0, done: 1'b1};

  function automatic ctrl_t ctrl_word(input state_e s);
    ctrl_t cw;
    cw = CW_IDLE;
    case (s)
      ST_LOAD:   cw = CW_LOAD;
      ST_ADD_AB: cw = CW_ADD_AB;
      ST_ADD_C:  cw = CW_ADD_C;
      ST_ADD_D:  cw = CW_ADD_D;
      ST_OUT:    cw = CW_OUT;
      ST_DONE:   cw = CW_DONE;
      default:   cw = CW_IDLE;
    endcase
    return cw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_controller.sv
`default_nettype none
// ============================================================================
// Module : adder_controller
// Brief  : Moore sequencer driving an external A+B+C+D datapath. Optional
//          op_count perf counter when ADDER_CONTROLLER_PERF_EN is defined.
// Rev    : 1.0
// ============================================================================
module adder_controller
  import adder_pkg::*;
#(
  parameter int unsigned DONE_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       aload,
  output logic       bload,
  output logic       cload,
  output logic       dload,
  output logic       asel,
  output logic [1:0] bsel,
  output logic       output_enable,
  output logic       busy,
  output logic       done
`ifdef ADDER_CONTROLLER_PERF_EN
  ,
  output logic [15:0] op_count
`endif
);

  localparam logic [3:0] HOLD_RELOAD = 4'(DONE_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  ctrl_t      cw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   state_d = abort ? ST_IDLE : ST_ADD_AB;
      ST_ADD_AB: state_d = abort ? ST_IDLE : ST_ADD_C;
      ST_ADD_C:  state_d = abort ? ST_IDLE : ST_ADD_D;
      ST_ADD_D:  state_d = abort ? ST_IDLE : ST_OUT;
      ST_OUT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          hold_d  = HOLD_RELOAD;
        end
      end
      ST_DONE: begin
        // Counter holds remaining extra cycles; zero means this is the last one.
        if (hold_q == 4'd0) state_d = ST_IDLE;
        else                hold_d  = hold_q - 4'd1;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  assign cw            = ctrl_word(state_q);
  assign aload         = cw.aload;
  assign bload         = cw.bload;
  assign cload         = cw.cload;
  assign dload         = cw.dload;
  assign asel          = cw.asel;
  assign bsel          = cw.bsel;
  assign output_enable = cw.output_enable;
  assign done          = cw.done;
  assign busy          = (state_q != ST_IDLE);

`ifdef ADDER_CONTROLLER_PERF_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_count_q <= 16'd0;
    end else if (state_q == ST_DONE && state_d == ST_IDLE) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_adder_controller
// Brief  : Two controllers (DONE_HOLD=1 and 4) each driving a behavioural
//          datapath, checked against a timeline model of each operation.
// Rev    : 1.0
// ============================================================================
module tb_adder_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort;
  logic [3:0] a_in, b_in, c_in, d_in;

  logic       aload [2], bload [2], cload [2], dload [2], asel [2];
  logic [1:0] bsel [2];
  logic       output_enable [2], busy [2], done [2];
`ifdef ADDER_CONTROLLER_PERF_EN
  logic [15:0] op_count [2];
`endif

  adder_controller #(.DONE_HOLD(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .aload(aload[0]), .bload(bload[0]), .cload(cload[0]), .dload(dload[0]),
    .asel(asel[0]), .bsel(bsel[0]), .output_enable(output_enable[0]),
    .busy(busy[0]), .done(done[0])
`ifdef ADDER_CONTROLLER_PERF_EN
    , .op_count(op_count[0])
`endif
  );

  adder_controller #(.DONE_HOLD(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .aload(aload[1]), .bload(bload[1]), .cload(cload[1]), .dload(dload[1]),
    .asel(asel[1]), .bsel(bsel[1]), .output_enable(output_enable[1]),
    .busy(busy[1]), .done(done[1])
`ifdef ADDER_CONTROLLER_PERF_EN
    , .op_count(op_count[1])
`endif
  );

  // Datapath driven by the controller strobes
  logic [3:0] ra [2], rb [2], rc [2], rd [2];
  logic [7:0] sum [2]   = '{8'd0, 8'd0};
  logic [7:0] o_sum [2] = '{8'd0, 8'd0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (aload[i]) ra[i] <= a_in;
      if (bload[i]) rb[i] <= b_in;
      if (cload[i]) rc[i] <= c_in;
      if (dload[i]) rd[i] <= d_in;
      if (asel[i])              sum[i] <= 8'(ra[i]) + 8'(rb[i]);
      else if (bsel[i] == 2'b01) sum[i] <= sum[i] + 8'(rc[i]);
      else if (bsel[i] == 2'b10) sum[i] <= sum[i] + 8'(rd[i]);
      if (output_enable[i]) o_sum[i] <= sum[i];
    end
  end

  // Model: age = cycles since start was accepted, -1 when idle
  int          hold [2] = '{1, 4};
  int          age [2];
  logic [7:0]  opv [2], exp_sum [2];
  logic [15:0] exp_cnt [2];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {busy, done, output_enable, aload, bload, cload, dload, asel, bsel}
  function automatic logic [9:0] exp_ctrl(input int a);
    logic       ld;
    logic [1:0] bs;
    ld = (a == 0);
    bs = (a == 1) ? 2'b00 : (a == 2) ? 2'b01 : (a == 3) ? 2'b10 : 2'b11;
    return {a >= 0, a >= 5, a == 4, ld, ld, ld, ld, a == 1, bs};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      age[i]     = -1;
      exp_cnt[i] = 16'd0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        age[i]     = -1;
        exp_cnt[i] = 16'd0;
      end else if (age[i] < 0) begin
        if (start) age[i] = 0;
      end else if (age[i] <= 4) begin
        if (age[i] == 0) opv[i] = 8'(a_in) + 8'(b_in) + 8'(c_in) + 8'(d_in);
        if (age[i] == 4) exp_sum[i] = opv[i];
        age[i] = abort ? -1 : age[i] + 1;
      end else begin
        age[i] = age[i] + 1;
        if (age[i] == 5 + hold[i]) begin
          age[i]     = -1;
          exp_cnt[i] = exp_cnt[i] + 16'd1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [9:0] obs;
    int         groups;
    for (int i = 0; i < 2; i++) begin
      obs = {busy[i], done[i], output_enable[i], aload[i], bload[i], cload[i],
             dload[i], asel[i], bsel[i]};
      chk($sformatf("ctrl%0d_age%0d", i, age[i]), 32'(obs), 32'(exp_ctrl(age[i])));
      chk($sformatf("osum%0d", i), 32'(o_sum[i]), 32'(exp_sum[i]));
      groups = int'(aload[i] | bload[i] | cload[i] | dload[i])
             + int'(asel[i] | (bsel[i] != 2'b11)) + int'(output_enable[i]);
      chk($sformatf("excl%0d", i), 32'(groups <= 1), 32'd1);
`ifdef ADDER_CONTROLLER_PERF_EN
      chk($sformatf("opcnt%0d", i), 32'(op_count[i]), 32'(exp_cnt[i]));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && (busy[0] || busy[1]); n++) step();
    chk("idle_wait", {30'd0, busy[0], busy[1]}, 32'd0);
  endtask

  task automatic set_ops(input logic [3:0] a, b, c, d);
    a_in = a; b_in = b; c_in = c; d_in = d;
  endtask

  int n_done0, n_done1;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    set_ops(4'd3, 4'd4, 4'd5, 4'd6);
    model_reset();
    exp_sum[0] = 8'd0; exp_sum[1] = 8'd0;
    #1;
    check_all();
    step();
    rst = 1'b1;

    // Scenario 1/2: single operation, 3+4+5+6, hold 1 and hold 4
    start = 1'b1;
    step();
    start = 1'b0;
    n_done0 = 0; n_done1 = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (n == 4) chk("s1_sum", 32'(o_sum[0]), 32'd18);
      n_done0 += int'(done[0]);
      n_done1 += int'(done[1]);
    end
    chk("s1_done_len", 32'(n_done0), 32'd1);
    chk("s2_done_len", 32'(n_done1), 32'd4);
    wait_idle();

    // Scenario 3: second start during ADD_C is ignored
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    start = 1'b1; step(); start = 1'b0;
    n_done0 = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (done[0] && !n_done0[0]) chk("s3_sum", 32'(o_sum[0]), 32'd18);
      n_done0 += int'(done[0]);
    end
    chk("s3_done_cnt", 32'(n_done0), 32'd1);
    wait_idle();

    // Scenario 4: abort during ADD_D, o_sum keeps 18
    set_ops(4'd1, 4'd1, 4'd1, 4'd1);
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("s4_busy", 32'(busy[0]), 32'd0);
    for (int n = 0; n < 4; n++) step();
    chk("s4_sum", 32'(o_sum[0]), 32'd18);
    wait_idle();

    // Scenario 5: asynchronous reset during ADD_AB, then 15*4
    set_ops(4'd15, 4'd15, 4'd15, 4'd15);
    start = 1'b1; step(); start = 1'b0;
    step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("s5_bsel", 32'(bsel[0]), 32'd3);
    step();
    rst = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 5; n++) step();
    chk("s5_sum", 32'(o_sum[0]), 32'd60);
    wait_idle();

`ifdef ADDER_CONTROLLER_PERF_EN
    // Scenario 6: back-to-back operations, one aborted, then wrap
    rst = 1'b0; step(); rst = 1'b1;
    start = 1'b1;
    for (int n = 0; n < 60 && exp_cnt[0] < 16'd3; n++) step();
    step(); step();
    abort = 1'b1; start = 1'b0; step(); abort = 1'b0;
    wait_idle();
    chk("s6_cnt", 32'(op_count[0]), 32'd3);
    force dut0.op_count_q = 16'hFFFF;
    #1 release dut0.op_count_q;
    exp_cnt[0] = 16'hFFFF;
    start = 1'b1; step(); start = 1'b0;
    wait_idle();
    chk("s6_wrap", 32'(op_count[0]), 32'd0);
`endif

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      start = ($urandom % 4) == 0;
      abort = ($urandom % 10) == 0;
      set_ops(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      step();
    end
    start = 1'b0; abort = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
